// File: rtl/delay_pkg.sv
// Shared types and helpers for the delay arbiter.
// Holds the FSM state type, default sizing and round-robin picker.
package delay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DELAY_N     = 25000;
  localparam int DELAY_CBITS = 15;
  localparam int MAXREQ      = 8;

  typedef struct packed {
    logic       any;
    logic [2:0] idx;
    logic [7:0] oh;
  } pick_t;

  // First set request at or after ptr, wrapping at nreq.
  function automatic pick_t rr_pick(
    input logic [7:0] req,
    input logic [2:0] ptr,
    input int         nreq
  );
    pick_t p;
    int    j;
    p = '0;
    for (int i = 0; i < MAXREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= nreq) j = j - nreq;
      if (i < nreq && !p.any && req[j[2:0]]) begin
        p.any        = 1'b1;
        p.idx        = j[2:0];
        p.oh[j[2:0]] = 1'b1;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/delay_arbiter_timer.sv
// Shared delay counter with registered range flags.
// err/flg track the value written on the same edge as cnt.
module delay_timer
  import delay_pkg::*;
#(
  parameter int N     = DELAY_N,
  parameter int CBITS = DELAY_CBITS
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_n,
  output logic err,
  output logic flg
);

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             flg_q, flg_d;

  // Next count and its bound flags.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CBITS'(1);
    end
    err_d = (cnt_d > CBITS'(N));
    flg_d = (cnt_d <= CBITS'(N));
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      flg_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      flg_q <= flg_d;
    end
  end

  assign at_n = (cnt_q == CBITS'(N));
  assign err  = err_q;
  assign flg  = flg_q;

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin owner of one shared delay counter.
// Grants, runs the delay, pulses done to the winner.
module delay_arbiter
  import delay_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int N     = DELAY_N,
  parameter int CBITS = DELAY_CBITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic            err,
  output logic            flg
);

  state_e          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [7:0]      req_w;
  logic [2:0]      win_nxt;
  pick_t           pick;
  logic            t_clr;
  logic            t_inc;
  logic            at_n;
  logic            own_req;

  // Widen requests to the picker's fixed width.
  always_comb begin
    req_w            = '0;
    req_w[NREQ-1:0]  = req;
  end

  assign pick    = rr_pick(req_w, ptr_q, NREQ);
  assign win_nxt = (win_q == 3'(NREQ-1)) ? 3'd0 : win_q + 3'd1;
  assign own_req = |(req & gnt_q);

  // Next-state, grant and timer control.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    t_clr   = 1'b0;
    t_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick.any) begin
          gnt_d   = NREQ'(pick.oh);
          win_d   = pick.idx;
          t_clr   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (at_n) begin
          t_clr   = 1'b1;
          done_d  = gnt_q;
          state_d = DONE;
        end else if (!own_req) begin
          gnt_d   = '0;
          t_clr   = 1'b1;
          ptr_d   = win_nxt;
          state_d = IDLE;
        end else begin
          t_inc = 1'b1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        ptr_d   = win_nxt;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        t_clr   = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  delay_timer #(
    .N     (N),
    .CBITS (CBITS)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (t_clr),
    .inc  (t_inc),
    .at_n (at_n),
    .err  (err),
    .flg  (flg)
  );

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_delay_arbiter.sv
// Bench for delay_arbiter: directed scenarios plus random soak.
// A grant-lifetime model predicts gnt/done/busy every cycle.
module tb_delay_arbiter;

  localparam int NR = 4;
  localparam int TN = 5;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] gnt;
  logic [NR-1:0] done;
  logic          busy;
  logic          err;
  logic          flg;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: current owner (-1 none), cycles since grant, rr pointer.
  int m_owner = -1;
  int m_age   = 0;
  int m_ptr   = 0;

  delay_arbiter #(
    .NREQ  (NR),
    .N     (TN),
    .CBITS (CB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .err  (err),
    .flg  (flg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input logic [NR-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  // Model update: one grant lives N+2 cycles unless its request drops.
  always @(posedge clk) begin
    int j;
    if (rst) begin
      m_owner = -1;
      m_age   = 0;
      m_ptr   = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < NR; i++) begin
        j = (m_ptr + i) % NR;
        if (m_owner < 0 && req[j]) begin
          m_owner = j;
          m_age   = 0;
        end
      end
    end else if (m_age == TN + 1) begin
      m_ptr   = (m_owner + 1) % NR;
      m_owner = -1;
    end else if (m_age < TN && !req[m_owner]) begin
      m_ptr   = (m_owner + 1) % NR;
      m_owner = -1;
    end else begin
      m_age++;
    end
  end

  // Per-cycle comparison against the model and soak invariants.
  logic [NR-1:0] pg_c = '0;
  int            rl   = 0;
  always @(negedge clk) begin
    logic [NR-1:0] eg;
    logic [NR-1:0] ed;
    if (chk_en) begin
      eg = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
      ed = (m_owner >= 0 && m_age == TN + 1) ? eg : '0;
      chk("m_gnt", 32'(gnt), 32'(eg));
      chk("m_done", 32'(done), 32'(ed));
      chk("m_busy", 32'(busy), 32'(m_owner >= 0));
      chk("m_err", 32'(err), 0);
      chk("m_flg", 32'(flg), 1);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      if (gnt != '0 && gnt == pg_c) rl++;
      else if (gnt != '0) rl = 1;
      else rl = 0;
      pg_c = gnt;
      if (done != '0) begin
        chk("done_hist_len", 32'(rl), 32'(TN + 2));
        chk("done_eq_gnt", 32'(done), 32'(gnt));
      end
    end
  end

  int            st_idx[$];
  int            st_cyc[$];
  int            exp_idx[4] = '{0, 1, 3, 0};
  int            exp_st[4]  = '{1, 9, 17, 25};
  logic [NR-1:0] pg;
  logic [NR-1:0] r;
  logic          rs;

  initial begin
    tick('0, 1'b1);
    chk_en = 1'b1;
    tick('0, 1'b1);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_flg", 32'(flg), 1);

    // Single request from index 0.
    for (int c = 1; c <= 8; c++) begin
      tick((c <= 7) ? 4'b0001 : 4'b0000, 1'b0);
      chk("single_gnt", 32'(gnt), (c <= 7) ? 1 : 0);
      chk("single_done", 32'(done), (c == 7) ? 1 : 0);
    end

    // Contention with 1011 held.
    tick('0, 1'b1);
    pg = '0;
    for (int c = 1; c <= 32; c++) begin
      tick(4'b1011, 1'b0);
      if (gnt != '0 && pg == '0) begin
        for (int b = 0; b < NR; b++)
          if (gnt[b]) st_idx.push_back(b);
        st_cyc.push_back(c);
      end
      pg = gnt;
    end
    chk("cont_ngrants", 32'(st_idx.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk("cont_idx", (i < st_idx.size()) ? 32'(st_idx[i]) : 32'hffff,
          32'(exp_idx[i]));
      chk("cont_start", (i < st_cyc.size()) ? 32'(st_cyc[i]) : 32'hffff,
          32'(exp_st[i]));
    end

    // Wrap-around: after index 3 completes, 1001 goes to index 0.
    tick('0, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      tick(4'b1000, 1'b0);
      if (c == 1) chk("wrap_gnt3", 32'(gnt), 32'h8);
      if (c == 7) chk("wrap_done3", 32'(done), 32'h8);
    end
    tick(4'b1001, 1'b0);
    chk("wrap_idle", 32'(gnt), 0);
    tick(4'b1001, 1'b0);
    chk("wrap_next0", 32'(gnt), 32'h1);

    // Abort at cnt 2, then next winner is index 3.
    tick('0, 1'b1);
    tick(4'b0100, 1'b0);
    chk("abort_gnt2", 32'(gnt), 32'h4);
    tick(4'b0100, 1'b0);
    tick(4'b0100, 1'b0);
    tick(4'b0000, 1'b0);
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_busy", 32'(busy), 0);
    tick(4'b1111, 1'b0);
    chk("abort_next3", 32'(gnt), 32'h8);

    // Reset mid-RUN at cnt 3.
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b0);
    tick(4'b1111, 1'b1);
    chk("mrst_gnt", 32'(gnt), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_flg", 32'(flg), 1);
    chk("mrst_err", 32'(err), 0);
    tick(4'b1111, 1'b0);
    chk("mrst_next0", 32'(gnt), 32'h1);

    // Random soak; owner never drops exactly when cnt reaches N.
    for (int c = 0; c < 10000; c++) begin
      r = req;
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(15) == 0) begin
          if (!(b == m_owner && r[b] && m_age == TN)) r[b] = ~r[b];
        end
      end
      rs = ($urandom_range(599) == 0);
      tick(r, rs);
    end

    tick('0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
